tick_timeout_timer: RTL and testbench
=====================================

// Module: tick_timeout_timer
// PURPOSE
//  Countdown timer clocked by the fast system clock and advanced by a slow tick square wave
//   (e.g. the divided clock from the tick divider). Consumer end of the tick interface.
//  Synchronises the tick, detects its rising edges, and counts down a loaded number of ticks.
//  Reports busy/done, a 1-cycle expiry pulse and the remaining count.
//  Used by the vending controller for coin-insert and dispense timeouts.
// PARAMETERS
//  CNT_W        16  width of load value and remaining count
//  SYNC_STAGES  2   flops in tick synchroniser, legal range >=2
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  tick       in   1      slow square wave, asynchronous to clk; rising edge = one tick
//  start      in   1      1-cycle strobe: load count and run (retriggers if already running)
//  load       in   CNT_W  tick count sampled when start=1
//  cancel     in   1      1-cycle strobe: abort and return to IDLE
//  pause      in   1      level: while high, ticks are not counted
//  busy       out  1      high in RUN or PAUSE
//  done       out  1      level: high in DONE until next start or cancel
//  expired    out  1      1-cycle pulse on entry to DONE
//  remaining  out  CNT_W  ticks still to count
//  tick_seen  out  1      1-cycle pulse per detected tick rising edge, ungated by state
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, expired=0, remaining=0, tick_seen=0; sync chain and
//   edge-history flop cleared to 0. A tick already high at reset release gives no edge.
//  Edge detect: tick_seen=1 in the cycle where sync_out=1 and prev=0.
//   Latency from tick rise to tick_seen is SYNC_STAGES+1 cycles (3 at default).
//  States: IDLE, RUN, PAUSE, DONE. Priority within a cycle: rst > cancel > start > pause > tick.
//  IDLE : start & load!=0 -> RUN, remaining<=load. start & load==0 -> DONE, expired=1 next cycle.
//  RUN  : cancel -> IDLE, remaining<=0. start -> reload, stay in RUN; a same-cycle tick is discarded.
//         pause -> PAUSE; a same-cycle tick is discarded.
//         tick_seen & remaining>1 -> remaining-1.
//         tick_seen & remaining==1 -> remaining<=0, DONE, expired=1 for the next cycle only.
//  PAUSE: remaining held. Ticks ignored. pause=0 -> RUN, with no catch-up of missed ticks.
//         cancel/start as in RUN.
//  DONE : done=1, remaining=0. start -> as in IDLE. cancel -> IDLE. Ticks ignored.
//  Outputs are registered: busy/done/expired reflect the current state/transition register.
//  No underflow: remaining never decrements below 0. Reload to all-ones is legal (2^CNT_W-1 ticks).
//  Asserting start and cancel together: cancel wins, timer goes IDLE, load is ignored.
//  rst mid-count: returns to IDLE next edge. A pending expired pulse is suppressed.
// STRUCTURE
//  Package tick_timer_pkg: state enum typedef (IDLE/RUN/PAUSE/DONE, 2-bit) and default CNT_W.
//  Sub-module tick_edge_detect: SYNC_STAGES sync chain plus history flop, outputs a rise pulse.
//   It has clk and rst and is reusable by other tick consumers.
//  Top module: state register, next-state logic, remaining counter, expired pulse register.
// TESTING  (tick period 20 clk, 50% duty, CNT_W=16)
//  load=3, start -> busy 1 next cycle; remaining 3,2,1,0 on successive tick_seen.
//   expired high exactly 1 cycle; done stays high.
//  load=0, start -> no RUN; expired=1 and done=1 the cycle after start; busy never high.
//  load=5, after 2 ticks hold pause for 60 clk -> remaining stays 3.
//   Resume: expiry after 3 more ticks (5 ticks total).
//  load=4, after 1 tick pulse start with load=10 -> remaining=10, counting restarts, no expired.
//  cancel at remaining=2 (also cancel+start same cycle) -> IDLE, remaining=0.
//   busy=done=expired=0, later ticks leave state unchanged.
//  tick high through rst release -> no tick_seen until next rising edge.
//   rst asserted on the expiry cycle -> expired never observed.

Source files
------------

// File: rtl/tick_timer_pkg.sv
// Shared types for the tick-driven timeout timer: state encoding and default count width.
package tick_timer_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/tick_edge_detect.sv
// Synchronises an asynchronous tick square wave into clk and emits a 1-cycle pulse per rising edge.
// A level that is already high when reset releases is treated as history, not as an edge.
module tick_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]   fill_q, fill_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;

  // fill_q marks when both the sync output and its history hold real post-reset samples
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tick};
    fill_d = {fill_q[SYNC_STAGES-1:0], 1'b1};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = fill_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      fill_q <= fill_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/tick_timeout_timer.sv
// Countdown timer advanced by rising edges of a slow asynchronous tick.
// Reports busy/done levels, a 1-cycle expiry pulse and the remaining tick count.
module tick_timeout_timer
  import tick_timer_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic [CNT_W-1:0] load,
  input  logic             cancel,
  input  logic             pause,
  output logic             busy,
  output logic             done,
  output logic             expired,
  output logic [CNT_W-1:0] remaining,
  output logic             tick_seen
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             expired_q, expired_d;
  logic             rise;

  tick_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk (clk),
    .rst (rst),
    .tick(tick),
    .rise(rise)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    expired_d   = 1'b0;
    if (cancel) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
    end else if (start) begin
      // A zero load expires immediately rather than entering RUN
      if (load != '0) begin
        state_d     = ST_RUN;
        remaining_d = load;
      end else begin
        state_d     = ST_DONE;
        remaining_d = '0;
        expired_d   = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (rise && (remaining_q > CNT_W'(1))) begin
            remaining_d = remaining_q - CNT_W'(1);
          end else if (rise && (remaining_q == CNT_W'(1))) begin
            state_d     = ST_DONE;
            remaining_d = '0;
            expired_d   = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          remaining_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      expired_q   <= expired_d;
    end
  end

  assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done      = (state_q == ST_DONE);
  assign expired   = expired_q;
  assign remaining = remaining_q;
  assign tick_seen = rise;

endmodule

// File: tb/tb_tick_timeout_timer.sv
// Directed bench for tick_timeout_timer: tick period 20 clk, hand-computed expectations.
module tb_tick_timeout_timer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick = 1'b0;
  logic             start;
  logic [CNT_W-1:0] load;
  logic             cancel;
  logic             pause;
  logic             busy;
  logic             done;
  logic             expired;
  logic [CNT_W-1:0] remaining;
  logic             tick_seen;

  logic             tick_run  = 1'b0;
  logic             tick_hold = 1'b0;
  int               tick_cnt  = 0;

  int n_cmp = 0;
  int n_err = 0;

  tick_timeout_timer #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .start    (start),
    .load     (load),
    .cancel   (cancel),
    .pause    (pause),
    .busy     (busy),
    .done     (done),
    .expired  (expired),
    .remaining(remaining),
    .tick_seen(tick_seen)
  );

  always #5 clk = ~clk;

  // Free-running tick: toggles every 10 clk when enabled, else follows tick_hold
  always begin
    @(posedge clk);
    #2;
    if (tick_run) begin
      if (tick_cnt == 9) begin
        tick_cnt = 0;
        tick     = ~tick;
      end else begin
        tick_cnt++;
      end
    end else begin
      tick     = tick_hold;
      tick_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_seen(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_seen && n < 100);
    if (!tick_seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] val);
    start = 1'b1;
    load  = val;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int seen_cnt;
    int exp_cnt;
    int lat;

    rst    = 1'b1;
    start  = 1'b0;
    load   = '0;
    cancel = 1'b0;
    pause  = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_expired", expired, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_tick_seen", tick_seen, 0);
    rst      = 1'b0;
    tick_run = 1'b1;
    repeat (3) @(negedge clk);

    // load=3: count 3,2,1,0 then expire
    pulse_start(16'd3);
    chk("l3_busy", busy, 1);
    chk("l3_rem3", remaining, 3);
    wait_seen("l3_t1");
    @(negedge clk);
    chk("l3_rem2", remaining, 2);
    wait_seen("l3_t2");
    @(negedge clk);
    chk("l3_rem1", remaining, 1);
    chk("l3_not_done", done, 0);
    wait_seen("l3_t3");
    @(negedge clk);
    chk("l3_rem0", remaining, 0);
    chk("l3_expired", expired, 1);
    chk("l3_done", done, 1);
    chk("l3_busy_off", busy, 0);
    @(negedge clk);
    chk("l3_expired_1cyc", expired, 0);
    chk("l3_done_held", done, 1);

    // load=0: immediate expiry, never busy
    pulse_start(16'd0);
    chk("l0_expired", expired, 1);
    chk("l0_done", done, 1);
    chk("l0_busy", busy, 0);
    @(negedge clk);
    chk("l0_expired_1cyc", expired, 0);
    chk("l0_busy2", busy, 0);

    // load=5 with a 60-clk pause after two ticks
    pulse_start(16'd5);
    wait_seen("p_t1");
    wait_seen("p_t2");
    @(negedge clk);
    chk("p_rem3", remaining, 3);
    pause = 1'b1;
    repeat (60) @(negedge clk);
    chk("p_held", remaining, 3);
    chk("p_busy", busy, 1);
    pause = 1'b0;
    wait_seen("p_t3");
    wait_seen("p_t4");
    @(negedge clk);
    chk("p_rem1", remaining, 1);
    chk("p_not_expired", expired, 0);
    wait_seen("p_t5");
    @(negedge clk);
    chk("p_expired", expired, 1);
    chk("p_rem0", remaining, 0);

    // load=4, retrigger with 10 after one tick
    pulse_start(16'd4);
    wait_seen("r_t1");
    @(negedge clk);
    chk("r_rem3", remaining, 3);
    pulse_start(16'd10);
    chk("r_rem10", remaining, 10);
    chk("r_busy", busy, 1);
    chk("r_no_expired", expired, 0);
    wait_seen("r_t2");
    @(negedge clk);
    chk("r_rem9", remaining, 9);

    // cancel at remaining=2
    pulse_start(16'd3);
    wait_seen("c_t1");
    @(negedge clk);
    chk("c_rem2", remaining, 2);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("c_busy", busy, 0);
    chk("c_done", done, 0);
    chk("c_expired", expired, 0);
    chk("c_rem", remaining, 0);
    wait_seen("c_t2");
    wait_seen("c_t3");
    @(negedge clk);
    chk("c_idle_busy", busy, 0);
    chk("c_idle_rem", remaining, 0);
    chk("c_idle_done", done, 0);

    // cancel and start together: cancel wins
    pulse_start(16'd7);
    chk("cs_rem7", remaining, 7);
    cancel = 1'b1;
    start  = 1'b1;
    load   = 16'd9;
    @(negedge clk);
    cancel = 1'b0;
    start  = 1'b0;
    chk("cs_rem", remaining, 0);
    chk("cs_busy", busy, 0);
    chk("cs_done", done, 0);

    // tick held high through reset release gives no edge
    tick_run  = 1'b0;
    tick_hold = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    seen_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (tick_seen) seen_cnt++;
    end
    chk("hi_rst_no_edge", seen_cnt, 0);
    tick_hold = 1'b0;
    repeat (5) @(negedge clk);
    tick_hold = 1'b1;
    @(posedge tick);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!tick_seen && lat < 10);
    chk("edge_latency", lat, 3);

    // reset on the expiry edge suppresses the pulse
    tick_hold = 1'b0;
    repeat (3) @(negedge clk);
    tick_run = 1'b1;
    pulse_start(16'd1);
    chk("re_busy", busy, 1);
    wait_seen("re_t1");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    repeat (6) begin
      if (expired) exp_cnt++;
      @(negedge clk);
    end
    chk("re_no_expired", exp_cnt, 0);
    chk("re_done", done, 0);
    chk("re_busy_off", busy, 0);
    chk("re_rem", remaining, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
